// File: rtl/mips_pkg.sv
// Shared MIPS write-back types: data/address widths, register address and word
// types, and the MEM/WB pipeline entry. Used by wb_stage and wb_scoreboard.
package mips_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_DEPTH = 5;
    localparam int WB_CNT_W = 2;

    typedef logic [WB_DEPTH-1:0] reg_addr_t;
    typedef logic [WB_WIDTH-1:0] word_t;

    // One MEM/WB slot: wflag is already cleared for writes aimed at $zero
    typedef struct packed {
        logic      wflag;
        reg_addr_t dst;
        word_t     data;
    } wb_entry_t;

    // Destination field select shared by every consumer of the RegDst control
    function automatic reg_addr_t selectDst(input logic regDst,
                                            input reg_addr_t rt,
                                            input reg_addr_t rd);
        return regDst ? rd : rt;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register,
// raised at issue and lowered when the matching write retires. Register 0 never
// counts. Optional macro WB_BYPASS_EN hides a hazard whose last pending write
// retires this cycle and flags it for same-cycle forwarding instead.
module wb_scoreboard
    import mips_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int CNT_W = WB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [DEPTH-1:0] iss_dst,
    input  logic             dec_valid,
    input  logic [DEPTH-1:0] dec_reg,
    input  logic [DEPTH-1:0] Reg1,
    input  logic [DEPTH-1:0] Reg2,
    output logic             hazard1,
    output logic             hazard2,
`ifdef WB_BYPASS_EN
    output logic             fwd1_en,
    output logic             fwd2_en,
`endif
    output logic             sb_overflow
);

    localparam int               NREG    = 1 << DEPTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_overflow;
    logic             w_inc;
    logic             w_dec;

    assign w_inc       = iss_valid && (iss_dst != '0);
    assign w_dec       = dec_valid && (dec_reg != '0);
    assign sb_overflow = r_overflow;

    // Per-register count update; a same-cycle issue and retire cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_inc && (iss_dst == DEPTH'(i)) &&
                    !(w_dec && (dec_reg == DEPTH'(i)))) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end else if (w_dec && (dec_reg == DEPTH'(i)) &&
                             !(w_inc && (iss_dst == DEPTH'(i)))) begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - CNT_ONE;
                    end
                end
            end
        end
    end

    // A retire with nothing reserved means issue and write-back disagree
    a_noUnderflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_dec && (r_cnt[dec_reg] == '0)));

`ifdef WB_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Hazard from counters, minus sources whose last pending write lands now
    always_comb begin
        w_byp1  = (Reg1 != '0) && (r_cnt[Reg1] == CNT_ONE) && w_dec && (dec_reg == Reg1);
        w_byp2  = (Reg2 != '0) && (r_cnt[Reg2] == CNT_ONE) && w_dec && (dec_reg == Reg2);
        hazard1 = (Reg1 != '0) && (r_cnt[Reg1] != '0) && !w_byp1;
        hazard2 = (Reg2 != '0) && (r_cnt[Reg2] != '0) && !w_byp2;
        fwd1_en = w_byp1;
        fwd2_en = w_byp2;
    end
`else
    // Hazard straight from counters; clears the cycle after the count hits 0
    always_comb begin
        hazard1 = (Reg1 != '0) && (r_cnt[Reg1] != '0);
        hazard2 = (Reg2 != '0) && (r_cnt[Reg2] != '0);
    end
`endif

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: one-entry MEM/WB register feeding the register-file
// write port through a valid/ready handshake, plus the pending-write scoreboard
// that decode consults for RAW hazards. Optional macro WB_BYPASS_EN adds the
// fwd1_en/fwd2_en/fwd_data forwarding outputs. WIDTH/DEPTH must match mips_pkg.
module wb_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = WB_DEPTH,
    parameter int CNT_W = WB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_RegWrite,
    input  logic             mem_memReg,
    input  logic             mem_RegDst,
    input  logic [DEPTH-1:0] mem_rt,
    input  logic [DEPTH-1:0] mem_rd,
    input  logic [WIDTH-1:0] mem_ALUres,
    input  logic [WIDTH-1:0] mem_RData,
    output logic             RegWrite,
    output logic [DEPTH-1:0] WriteReg,
    output logic [WIDTH-1:0] WriteData,
    input  logic             wb_ready,
    input  logic             iss_valid,
    input  logic [DEPTH-1:0] iss_dst,
    input  logic [DEPTH-1:0] Reg1,
    input  logic [DEPTH-1:0] Reg2,
    output logic             hazard1,
    output logic             hazard2,
`ifdef WB_BYPASS_EN
    output logic             fwd1_en,
    output logic             fwd2_en,
    output logic [WIDTH-1:0] fwd_data,
`endif
    output logic             sb_overflow
);

    wb_entry_t r_entry;
    logic      r_full;
    wb_entry_t w_next;
    reg_addr_t w_dst;
    logic      w_accept;
    logic      w_retire;
    logic      w_decValid;

    assign mem_ready  = !r_full || wb_ready;
    assign w_accept   = mem_valid && mem_ready;
    assign w_retire   = r_full && wb_ready;
    assign w_dst      = selectDst(mem_RegDst, mem_rt, mem_rd);
    assign w_decValid = w_retire && r_entry.wflag;

    // Build the entry to capture: data mux, destination mux, $zero suppression
    always_comb begin
        w_next       = '0;
        w_next.dst   = w_dst;
        w_next.data  = mem_memReg ? mem_RData : mem_ALUres;
        w_next.wflag = mem_RegWrite && (w_dst != '0);
    end

    // MEM/WB slot: refill on accept, otherwise drain on retire, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (w_accept) begin
            r_full  <= 1'b1;
            r_entry <= w_next;
        end else if (w_retire) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end
    end

    assign RegWrite  = r_full && r_entry.wflag;
    assign WriteReg  = r_entry.dst;
    assign WriteData = r_entry.data;

`ifdef WB_BYPASS_EN
    assign fwd_data = r_entry.data;
`endif

    wb_scoreboard #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_dst     (iss_dst),
        .dec_valid   (w_decValid),
        .dec_reg     (r_entry.dst),
        .Reg1        (Reg1),
        .Reg2        (Reg2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
`ifdef WB_BYPASS_EN
        .fwd1_en     (fwd1_en),
        .fwd2_en     (fwd2_en),
`endif
        .sb_overflow (sb_overflow)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register-file writes are queued when
// the MEM-side instruction is accepted and compared when the write port fires.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        memValid;
    logic        memReady;
    logic        memRegWrite;
    logic        memMemReg;
    logic        memRegDst;
    logic [4:0]  memRt;
    logic [4:0]  memRd;
    logic [31:0] memAluRes;
    logic [31:0] memRData;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        wbReady;
    logic        issValid;
    logic [4:0]  issDst;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic        hazard1;
    logic        hazard2;
    logic        sbOverflow;
`ifdef WB_BYPASS_EN
    logic        fwd1En;
    logic        fwd2En;
    logic [31:0] fwdData;
`endif

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } expWrite_t;

    expWrite_t expQ[$];
    expWrite_t monExp;
    int        checks   = 0;
    int        failures = 0;

    wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (memValid),
        .mem_ready    (memReady),
        .mem_RegWrite (memRegWrite),
        .mem_memReg   (memMemReg),
        .mem_RegDst   (memRegDst),
        .mem_rt       (memRt),
        .mem_rd       (memRd),
        .mem_ALUres   (memAluRes),
        .mem_RData    (memRData),
        .RegWrite     (regWrite),
        .WriteReg     (writeReg),
        .WriteData    (writeData),
        .wb_ready     (wbReady),
        .iss_valid    (issValid),
        .iss_dst      (issDst),
        .Reg1         (reg1),
        .Reg2         (reg2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
`ifdef WB_BYPASS_EN
        .fwd1_en      (fwd1En),
        .fwd2_en      (fwd2En),
        .fwd_data     (fwdData),
`endif
        .sb_overflow  (sbOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rw, input logic memReg,
                                 input logic regDst, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] rdata);
        memValid    = valid;
        memRegWrite = rw;
        memMemReg   = memReg;
        memRegDst   = regDst;
        memRt       = rt;
        memRd       = rd;
        memAluRes   = alu;
        memRData    = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every write the register file takes must be the oldest queued expectation
    always @(negedge clk) begin
        if (rst && regWrite && wbReady) begin
            checks++;
            assert (expQ.size() != 0) else begin
                failures++;
                $error("[TB] FAIL wr_unexpected observed=%0h:%0h expected=none", writeReg, writeData);
            end
            if (expQ.size() != 0) begin
                monExp = expQ.pop_front();
                checkOutput("wr_reg", 32'(writeReg), 32'(monExp.dst));
                checkOutput("wr_data", writeData, monExp.data);
            end
        end
    end

    initial begin
        rst      = 1'b0;
        wbReady  = 1'b1;
        issValid = 1'b0;
        issDst   = 5'd0;
        reg1     = 5'd5;
        reg2     = 5'd8;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd8, 32'h0000_00AA, 32'h0000_1234);
        #12;
        checkOutput("rst_regwrite", 32'(regWrite), 0);
        checkOutput("rst_writereg", 32'(writeReg), 0);
        checkOutput("rst_writedata", writeData, 0);
        checkOutput("rst_hazard1", 32'(hazard1), 0);
        checkOutput("rst_hazard2", 32'(hazard2), 0);
        checkOutput("rst_overflow", 32'(sbOverflow), 0);
        memValid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("rst_memready", 32'(memReady), 1);

        // Basic ALU write to rd=8
        issValid = 1'b1;
        issDst   = 5'd8;
        tick();
        issValid = 1'b0;
        reg1     = 5'd8;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd8, 32'h0000_00AA, 32'h0000_1234);
        expQ.push_back('{dst: 5'd8, data: 32'h0000_00AA});
        #1;
        checkOutput("alu_memready", 32'(memReady), 1);
        checkOutput("alu_haz_before", 32'(hazard1), 1);
        tick();
        memValid = 1'b0;
        checkOutput("alu_regwrite", 32'(regWrite), 1);
        checkOutput("alu_writereg", 32'(writeReg), 8);
        checkOutput("alu_writedata", writeData, 32'h0000_00AA);
`ifdef WB_BYPASS_EN
        checkOutput("alu_haz_retire", 32'(hazard1), 0);
        checkOutput("alu_fwd1", 32'(fwd1En), 1);
        checkOutput("alu_fwddata", fwdData, 32'h0000_00AA);
`else
        checkOutput("alu_haz_retire", 32'(hazard1), 1);
`endif
        tick();
        checkOutput("alu_one_cycle", 32'(regWrite), 0);
        checkOutput("alu_haz_after", 32'(hazard1), 0);

        // Stalled load to rt=3, then same-cycle retire and refill
        issValid = 1'b1;
        issDst   = 5'd3;
        tick();
        issDst   = 5'd10;
        tick();
        issValid = 1'b0;
        wbReady  = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd9, 32'h0000_0055, 32'hDEAD_BEEF);
        expQ.push_back('{dst: 5'd3, data: 32'hDEAD_BEEF});
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 5'd10, 32'h1111_2222, 32'h0000_0000);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_memready", 32'(memReady), 0);
            checkOutput("stall_regwrite", 32'(regWrite), 1);
            checkOutput("stall_writereg", 32'(writeReg), 3);
            checkOutput("stall_writedata", writeData, 32'hDEAD_BEEF);
            tick();
        end
        wbReady = 1'b1;
        expQ.push_back('{dst: 5'd10, data: 32'h1111_2222});
        #1;
        checkOutput("unstall_memready", 32'(memReady), 1);
        tick();
        memValid = 1'b0;
        checkOutput("refill_regwrite", 32'(regWrite), 1);
        checkOutput("refill_writereg", 32'(writeReg), 10);
        checkOutput("refill_writedata", writeData, 32'h1111_2222);
        tick();
        checkOutput("refill_drained", 32'(regWrite), 0);

        // Writes to $zero and non-writing instructions never strobe
        reg1     = 5'd0;
        issValid = 1'b1;
        issDst   = 5'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 32'h0000_0077, 32'h0000_0000);
        #1;
        checkOutput("r0_haz_issue", 32'(hazard1), 0);
        tick();
        issValid = 1'b0;
        memValid = 1'b0;
        checkOutput("r0_regwrite", 32'(regWrite), 0);
        checkOutput("r0_hazard", 32'(hazard1), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd6, 32'h0000_0066, 32'h0000_0000);
        tick();
        memValid = 1'b0;
        checkOutput("nowrite_regwrite", 32'(regWrite), 0);
        checkOutput("nowrite_memready", 32'(memReady), 1);
        tick();

        // Two writes in flight to reg 5, then saturation
        reg1     = 5'd5;
        reg2     = 5'd6;
        issValid = 1'b1;
        issDst   = 5'd5;
        tick();
        tick();
        issValid = 1'b0;
        checkOutput("sb_haz1_two", 32'(hazard1), 1);
        checkOutput("sb_haz2_idle", 32'(hazard2), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 32'h0000_0501, 32'h0000_0000);
        expQ.push_back('{dst: 5'd5, data: 32'h0000_0501});
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 32'h0000_0502, 32'h0000_0000);
        expQ.push_back('{dst: 5'd5, data: 32'h0000_0502});
        #1;
        checkOutput("sb_haz_first_retire", 32'(hazard1), 1);
        tick();
        memValid = 1'b0;
`ifdef WB_BYPASS_EN
        checkOutput("sb_haz_second_retire", 32'(hazard1), 0);
        checkOutput("sb_fwd1", 32'(fwd1En), 1);
        checkOutput("sb_fwddata", fwdData, 32'h0000_0502);
`else
        checkOutput("sb_haz_second_retire", 32'(hazard1), 1);
`endif
        tick();
        checkOutput("sb_haz_clear", 32'(hazard1), 0);
        issValid = 1'b1;
        issDst   = 5'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        checkOutput("sb_sat_no_ovf", 32'(sbOverflow), 0);
        tick();
        issValid = 1'b0;
        checkOutput("sb_overflow", 32'(sbOverflow), 1);
        checkOutput("sb_sat_haz", 32'(hazard1), 1);

        // Issue and retire to reg 7 in the same cycle keeps the count at 1
        reg2     = 5'd7;
        issValid = 1'b1;
        issDst   = 5'd7;
        tick();
        issValid = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd7, 32'h0000_0700, 32'h0000_0000);
        expQ.push_back('{dst: 5'd7, data: 32'h0000_0700});
        tick();
        memValid = 1'b0;
        issValid = 1'b1;
        issDst   = 5'd7;
        #1;
        checkOutput("sim_regwrite", 32'(regWrite), 1);
        tick();
        issValid = 1'b0;
        checkOutput("sim_haz", 32'(hazard2), 1);
        tick();
        checkOutput("sim_haz_persist", 32'(hazard2), 1);

        // Reset during a stall drops the entry immediately
        wbReady = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd7, 32'h0000_0770, 32'h0000_0000);
        tick();
        memValid = 1'b0;
        checkOutput("midrst_pre", 32'(regWrite), 1);
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midrst_regwrite", 32'(regWrite), 0);
        checkOutput("midrst_writereg", 32'(writeReg), 0);
        checkOutput("midrst_writedata", writeData, 0);
        checkOutput("midrst_hazard2", 32'(hazard2), 0);
        checkOutput("midrst_overflow", 32'(sbOverflow), 0);
        rst     = 1'b1;
        wbReady = 1'b1;
        tick();
        checkOutput("postrst_regwrite", 32'(regWrite), 0);
        checkOutput("postrst_memready", 32'(memReady), 1);

        checkOutput("queue_empty", 32'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
